// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the ALU result-select datapath: valid/ready request in, decoded
// operands out, captured result on a valid/ready response. ALU_SEQ_FASTSHIFT_EN selects single-cycle shifts.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       fn_class,
    output logic [1:0]       sub_op,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] fn_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    localparam logic [2:0] CLS_SHIFT = 3'b101;
    localparam logic [2:0] CLS_ZERO  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       fn_class_q, fn_class_d;
    logic [1:0]       sub_op_q, sub_op_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
`ifndef ALU_SEQ_FASTSHIFT_EN
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             more_c;
`endif

    logic [2:0] dec_class_c;
    logic [1:0] dec_sub_c;

    // Opcode to function class / sub-op; class 111 marks an illegal opcode
    always_comb begin
        dec_class_c = CLS_ZERO;
        dec_sub_c   = 2'd0;
        case (req_op)
            4'd0:  dec_class_c = 3'b000;
            4'd1:  dec_class_c = 3'b001;
            4'd2:  dec_class_c = 3'b010;
            4'd3:  dec_class_c = 3'b011;
            4'd4:  begin dec_class_c = 3'b011; dec_sub_c = 2'd1; end
            4'd5:  dec_class_c = 3'b100;
            4'd6:  begin dec_class_c = 3'b100; dec_sub_c = 2'd1; end
            4'd7:  begin dec_class_c = 3'b100; dec_sub_c = 2'd2; end
            4'd8:  begin dec_class_c = 3'b100; dec_sub_c = 2'd3; end
            4'd9:  dec_class_c = CLS_SHIFT;
            4'd10: begin dec_class_c = CLS_SHIFT; dec_sub_c = 2'd1; end
            4'd11: begin dec_class_c = CLS_SHIFT; dec_sub_c = 2'd2; end
            4'd12: dec_class_c = 3'b110;
            default: ;
        endcase
    end

`ifndef ALU_SEQ_FASTSHIFT_EN
    assign more_c = (fn_class_q == CLS_SHIFT) && (cnt_q > SHW'(1));
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        fn_class_d  = fn_class_q;
        sub_op_d    = sub_op_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
`ifndef ALU_SEQ_FASTSHIFT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    op_a_d      = req_a;
                    op_b_d      = req_b;
                    rsp_err_d   = 1'b0;
                    if (dec_class_c == CLS_ZERO) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        fn_class_d  = CLS_ZERO;
                        sub_op_d    = 2'd0;
                    end else begin
                        state_d    = EXEC;
                        fn_class_d = dec_class_c;
                        sub_op_d   = dec_sub_c;
`ifndef ALU_SEQ_FASTSHIFT_EN
                        // Iterative shifts step one bit per cycle; shamt 0 passes op_a through
                        if (dec_class_c == CLS_SHIFT) begin
                            cnt_d  = req_b[SHW-1:0];
                            op_b_d = (req_b[SHW-1:0] != '0) ? WIDTH'(1) : '0;
                        end
`endif
                    end
                end
            end
            EXEC: begin
`ifndef ALU_SEQ_FASTSHIFT_EN
                if (more_c) begin
                    op_a_d = fn_result;
                    cnt_d  = cnt_q - SHW'(1);
                end else begin
                    cnt_d = '0;
`else
                begin
`endif
                    rsp_data_d  = fn_result;
                    rsp_valid_d = 1'b1;
                    fn_class_d  = CLS_ZERO;
                    sub_op_d    = 2'd0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            fn_class_q  <= CLS_ZERO;
            sub_op_q    <= 2'd0;
            op_a_q      <= '0;
            op_b_q      <= '0;
`ifndef ALU_SEQ_FASTSHIFT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            fn_class_q  <= fn_class_d;
            sub_op_q    <= sub_op_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
`ifndef ALU_SEQ_FASTSHIFT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign fn_class  = fn_class_q;
    assign sub_op    = sub_op_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: datapath model, directed scenarios and random ops
// checked against a whole-operation reference (full shifts, latency from the op rules).
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [2:0]  fn_class;
    logic [1:0]  sub_op;
    logic [31:0] op_a, op_b;
    logic [31:0] fn_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .fn_class(fn_class), .sub_op(sub_op), .op_a(op_a), .op_b(op_b),
        .fn_result(fn_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Result-select datapath driven by the controller's operands
    always_comb begin
        fn_result = '0;
        case (fn_class)
            3'b000: fn_result = op_b << 16;
            3'b001: fn_result = {31'd0, $signed(op_a) < $signed(op_b)};
            3'b010: fn_result = {31'd0, $signed(op_a) > $signed(op_b)};
            3'b011: fn_result = (sub_op == 2'd1) ? op_a - op_b : op_a + op_b;
            3'b100: case (sub_op)
                        2'd0: fn_result = op_a & op_b;
                        2'd1: fn_result = op_a | op_b;
                        2'd2: fn_result = op_a ^ op_b;
                        default: fn_result = ~(op_a | op_b);
                    endcase
            3'b101: case (sub_op)
                        2'd0: fn_result = op_a << op_b[4:0];
                        2'd1: fn_result = op_a >> op_b[4:0];
                        2'd2: fn_result = 32'($signed(op_a) >>> op_b[4:0]);
                        default: fn_result = '0;
                    endcase
            3'b110: fn_result = 32'($countones(op_a ^ op_b));
            default: fn_result = '0;
        endcase
    end

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:  return b << 16;
            4'd1:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd2:  return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  return a + b;
            4'd4:  return a - b;
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return a ^ b;
            4'd8:  return ~(a | b);
            4'd9:  return a << sh;
            4'd10: return a >> sh;
            4'd11: return 32'($signed(a) >>> sh);
            4'd12: return 32'($countones(a ^ b));
            default: return 32'd0;
        endcase
    endfunction

    // Edges from accept to the first edge that sees rsp_valid high
    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if (op > 4'd12) return 1;
`ifndef ALU_SEQ_FASTSHIFT_EN
        if (op >= 4'd9 && op <= 4'd11) return (b[4:0] == 5'd0) ? 2 : 1 + int'(b[4:0]);
`endif
        return 2;
    endfunction

    // One complete transaction; called at a negedge with the controller idle
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit pre,
                          output logic [2:0] cls0, output logic [1:0] sub0, output logic [31:0] got);
        int j;
        logic [31:0] exp_d;
        int exp_l;
        exp_d = ref_res(op, a, b);
        exp_l = ref_lat(op, b);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready op=%0d got=%b want=1", op, req_ready); end
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 4'($urandom);
        cls0 = fn_class; sub0 = sub_op;
        j = 0;
        while (!rsp_valid && j < 100) begin
            total++;
            if (req_ready !== 1'b0) begin bad++; $display("FAIL busy_ready op=%0d got=%b want=0", op, req_ready); end
            @(negedge clk);
            j++;
        end
        got = rsp_data;
        total++;
        if (j + 1 != exp_l) begin bad++; $display("FAIL latency op=%0d b=%h got=%0d want=%0d", op, b, j + 1, exp_l); end
        total++;
        if (rsp_data !== exp_d) begin bad++; $display("FAIL rsp_data op=%0d a=%h b=%h got=%h want=%h", op, a, b, rsp_data, exp_d); end
        total++;
        if (rsp_err !== (op > 4'd12)) begin bad++; $display("FAIL rsp_err op=%0d got=%b want=%b", op, rsp_err, op > 4'd12); end
        if (pre) begin req_op = 4'd3; req_a = 32'd1; req_b = 32'd2; req_valid = 1'b1; end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold op=%0d valid=%b data=%h ready=%b want 1/%h/0", op, rsp_valid, rsp_data, req_ready, exp_d);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake op=%0d valid=%b ready=%b want 0/1", op, rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0 ||
            fn_class !== 3'b111 || sub_op !== 2'd0 || op_a !== 32'd0 || op_b !== 32'd0) begin
            bad++;
            $display("FAIL %s rdy=%b vld=%b data=%h err=%b cls=%b sub=%0d a=%h b=%h want 1/0/0/0/111/0/0/0",
                     tag, req_ready, rsp_valid, rsp_data, rsp_err, fn_class, sub_op, op_a, op_b);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_vals("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_release");
    endtask

    task automatic test_add();
        logic [2:0] c; logic [1:0] s; logic [31:0] g;
        run_op(4'd3, 32'h7FFF_FFFF, 32'd1, 0, 1'b0, c, s, g);
        total++;
        if (c !== 3'b011 || s !== 2'd0) begin bad++; $display("FAIL add_decode cls=%b sub=%0d want 011/0", c, s); end
        total++;
        if (g !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h want=80000000", g); end
    endtask

    task automatic test_shift();
        logic [2:0] c; logic [1:0] s; logic [31:0] g;
        run_op(4'd11, 32'h8000_0000, 32'd31, 0, 1'b0, c, s, g);
        total++;
        if (g !== 32'hFFFF_FFFF || c !== 3'b101 || s !== 2'd2) begin
            bad++; $display("FAIL sra31 got=%h cls=%b sub=%0d want ffffffff/101/2", g, c, s);
        end
        run_op(4'd9, 32'h1234_5678, 32'd0, 0, 1'b0, c, s, g);
        total++;
        if (g !== 32'h1234_5678) begin bad++; $display("FAIL sll0 got=%h want=12345678", g); end
        run_op(4'd10, 32'hF000_000F, 32'd1, 1, 1'b0, c, s, g);
        run_op(4'd9, 32'h0000_0003, 32'hFFFF_FFE2, 0, 1'b0, c, s, g);
    endtask

    task automatic test_illegal();
        logic [2:0] c; logic [1:0] s; logic [31:0] g;
        run_op(4'd14, 32'hDEAD_BEEF, 32'h1234_5678, 2, 1'b0, c, s, g);
        total++;
        if (c !== 3'b111 || g !== 32'd0) begin bad++; $display("FAIL illegal cls=%b data=%h want 111/0", c, g); end
    endtask

    task automatic test_back_pressure();
        logic [2:0] c; logic [1:0] s; logic [31:0] g;
        run_op(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 1'b1, c, s, g);
        total++;
        if (g !== 32'h0FF0_0FF0) begin bad++; $display("FAIL xor_bp got=%h want=0ff00ff0", g); end
        run_op(4'd3, 32'd1, 32'd2, 0, 1'b0, c, s, g);
    endtask

    task automatic test_back_to_back();
        int acc; int rsp; int k;
        acc = 0; rsp = 0;
        req_op = 4'd3; req_a = 32'd5; req_b = 32'd7; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (req_ready) acc++;
            if (rsp_valid) begin
                rsp++;
                total++;
                if (rsp_data !== 32'd12) begin bad++; $display("FAIL b2b_data got=%h want=0000000c", rsp_data); end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        k = 0;
        while (!req_ready && k < 10) begin @(negedge clk); k++; end
        rsp_ready = 1'b0;
        total++;
        if (acc != 10 || rsp != 10) begin bad++; $display("FAIL b2b_rate accepts=%0d resps=%0d want 10/10", acc, rsp); end
    endtask

    task automatic test_random();
        logic [2:0] c; logic [1:0] s; logic [31:0] g;
        logic [31:0] b;
        for (int n = 0; n < 150; n++) begin
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            run_op(4'($urandom_range(0, 15)), $urandom, b, $urandom_range(0, 3), 1'b0, c, s, g);
        end
    endtask

    task automatic test_reset_midop();
        int k;
        req_op = 4'd9; req_a = 32'hA5A5_0001; req_b = 32'd20; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("reset_midop");
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) k++;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        total++;
        if (k != 0) begin bad++; $display("FAIL reset_no_rsp bad_cycles=%0d want=0", k); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_illegal();
        test_back_pressure();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
